// File: rtl/vector_mem_sequencer.sv
// rtl/vector_mem_sequencer.sv - serialises vector loads/stores into strided single-element memory accesses
module vector_mem_sequencer #(
    parameter int N     = 32,
    parameter int LANES = 4,
    parameter int AW    = 32,
    parameter int LW    = $clog2(LANES + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [1:0]         req_op,
    input  logic [LW-1:0]      req_len,
    input  logic [AW-1:0]      base_addr,
    input  logic [AW-1:0]      stride,
    input  logic [LANES*N-1:0] store_vector,
    output logic [AW-1:0]      mem_addr,
    output logic [N-1:0]       mem_wdata,
    output logic               mem_we,
    output logic               mem_re,
    input  logic [N-1:0]       mem_rdata,
    output logic [LANES*N-1:0] load_vector,
    output logic               done,
    output logic               stall_cpu
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_store;
    logic [LW-1:0]      r_count;
    logic [LW-1:0]      r_idx;
    logic [AW-1:0]      r_addr;
    logic [AW-1:0]      r_stride;
    logic [LANES*N-1:0] r_store_vec;
    logic [LANES*N-1:0] r_load;

    logic               w_accept;
    logic               w_last;
    logic [LW-1:0]      w_len;
    logic               w_cap_en;
    logic [LW-1:0]      w_cap_lane;
    logic [N-1:0]       w_wdata;

    assign w_accept = req_valid && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == (r_count - LW'(1)));
    assign w_len    = ((req_len == '0) || (req_len > LW'(LANES))) ? LW'(LANES) : req_len;

    // Read data lags the strobe by one cycle, so RUN captures the previous lane and DRAIN the last.
    assign w_cap_en   = !r_store && (((r_state == S_RUN) && (r_idx != '0)) || (r_state == S_DRAIN));
    assign w_cap_lane = (r_state == S_DRAIN) ? r_idx : (r_idx - LW'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = r_store ? S_DONE : S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == LW'(i)) w_wdata = r_store_vec[i*N +: N];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_store     <= 1'b0;
            r_count     <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_stride    <= '0;
            r_store_vec <= '0;
            r_load      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_store     <= req_op[0];
                r_count     <= req_op[1] ? w_len : LW'(1);
                r_idx       <= '0;
                r_addr      <= base_addr;
                r_stride    <= stride;
                r_store_vec <= store_vector;
            end else if (r_state == S_RUN) begin
                r_addr <= r_addr + r_stride;
                if (!w_last) r_idx <= r_idx + LW'(1);
            end
            if (w_accept && !req_op[0]) begin
                r_load <= '0;
            end else if (w_cap_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (w_cap_lane == LW'(i)) r_load[i*N +: N] <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = w_wdata;
    assign mem_we      = (r_state == S_RUN) && r_store;
    assign mem_re      = (r_state == S_RUN) && !r_store;
    assign load_vector = r_load;
    assign done        = (r_state == S_DONE);
    assign stall_cpu   = (r_state == S_RUN) || (r_state == S_DRAIN) || w_accept;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// tb/tb_vector_mem_sequencer.sv - scoreboard bench for vector_mem_sequencer
module tb_vector_mem_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [1:0]   req_op;
    logic [2:0]   req_len;
    logic [31:0]  base_addr;
    logic [31:0]  stride;
    logic [127:0] store_vector;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_we;
    logic         mem_re;
    logic [31:0]  mem_rdata;
    logic [127:0] load_vector;
    logic         done;
    logic         stall_cpu;

    vector_mem_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_len(req_len),
        .base_addr(base_addr), .stride(stride), .store_vector(store_vector),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .load_vector(load_vector), .done(done), .stall_cpu(stall_cpu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t         exp_q[$];
    logic [31:0]  mem_map [logic [31:0]];
    logic [127:0] exp_lv;
    int           checks = 0;
    int           errors = 0;

    function automatic logic [31:0] model(input logic [31:0] a);
        if (mem_map.exists(a)) return mem_map[a];
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory: read data appears the cycle after mem_re
    initial begin
        logic [31:0] ra;
        forever begin
            @(negedge clk);
            if (mem_re === 1'b1) begin
                ra = mem_addr;
                @(posedge clk);
                #1 mem_rdata = model(ra);
            end
        end
    end

    // Access monitor: every strobe must match the next scoreboard entry
    initial begin
        acc_t e;
        forever begin
            @(negedge clk);
            if (mem_we === 1'b1 || mem_re === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_access we=%0b re=%0b addr=%h", mem_we, mem_re, mem_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (mem_we !== e.we || mem_re !== !e.we || mem_addr !== e.addr ||
                        (e.we && mem_wdata !== e.data)) begin
                        errors++;
                        $display("FAIL access got we=%0b re=%0b addr=%h data=%h expected we=%0b addr=%h data=%h",
                                 mem_we, mem_re, mem_addr, mem_wdata, e.we, e.addr, e.data);
                    end
                end
            end
        end
    end

    task automatic push_expect(input logic [1:0] op, input logic [2:0] len, input logic [31:0] base,
                               input logic [31:0] str, input logic [127:0] vec);
        int          k;
        logic [31:0] a;
        k = op[1] ? ((len == 0 || len > 4) ? 4 : int'(len)) : 1;
        exp_lv = '0;
        a = base;
        for (int i = 0; i < k; i++) begin
            exp_q.push_back('{we: op[0], addr: a, data: vec[i*32 +: 32]});
            if (!op[0]) exp_lv[i*32 +: 32] = model(a);
            a = a + str;
        end
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [2:0] len, input logic [31:0] base,
                             input logic [31:0] str, input logic [127:0] vec);
        req_op = op; req_len = len; base_addr = base; stride = str; store_vector = vec;
        req_valid = 1'b1;
        push_expect(op, len, base, str, vec);
    endtask

    task automatic run_seq(input logic [1:0] op, input logic [2:0] len, input logic [31:0] base,
                           input logic [31:0] str, input logic [127:0] vec,
                           output int lat, output int stalls);
        @(posedge clk); #1;
        drive_req(op, len, base, str, vec);
        @(negedge clk);
        stalls = (stall_cpu === 1'b1) ? 1 : 0;
        @(posedge clk); #1 req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (stall_cpu === 1'b1) stalls++;
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, done, stall_cpu} !== 4'b0 || mem_addr !== 0 || mem_wdata !== 0 || load_vector !== 0) begin
            errors++;
            $display("FAIL reset_state we=%0b re=%0b done=%0b stall=%0b addr=%h wdata=%h lv=%h expected all 0",
                     mem_we, mem_re, done, stall_cpu, mem_addr, mem_wdata, load_vector);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, done, stall_cpu} !== 4'b0) begin
            errors++;
            $display("FAIL idle_after_reset strobes=%b expected 0000", {mem_we, mem_re, done, stall_cpu});
        end
    endtask

    task automatic test_vector_store();
        int lat, st;
        run_seq(2'b11, 3'd4, 32'h100, 32'd4, {32'hD, 32'hC, 32'hB, 32'hA}, lat, st);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL vstore_latency got %0d expected 5", lat); end
        checks++;
        if (st != 5) begin errors++; $display("FAIL vstore_stall got %0d expected 5", st); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL vstore_missing got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_vector_load();
        int lat, st;
        mem_map[32'h200] = 32'h11; mem_map[32'h208] = 32'h22;
        mem_map[32'h210] = 32'h33; mem_map[32'h218] = 32'h44;
        run_seq(2'b10, 3'd4, 32'h200, 32'd8, '0, lat, st);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL vload_latency got %0d expected 6", lat); end
        checks++;
        if (st != 6) begin errors++; $display("FAIL vload_stall got %0d expected 6", st); end
        @(posedge clk); #1;
        checks++;
        if (load_vector !== {32'h44, 32'h33, 32'h22, 32'h11}) begin
            errors++; $display("FAIL vload_data got %h expected %h", load_vector, {32'h44, 32'h33, 32'h22, 32'h11});
        end
    endtask

    task automatic test_scalar();
        int lat, st;
        run_seq(2'b01, 3'd3, 32'h40, 32'd4, {32'h77, 32'h66, 32'h55, 32'h5}, lat, st);
        checks++;
        if (lat != 2 || exp_q.size() != 0) begin
            errors++; $display("FAIL scalar_store got lat=%0d pending=%0d expected lat=2 pending=0", lat, exp_q.size());
        end
        mem_map[32'h80] = 32'h9;
        run_seq(2'b00, 3'd4, 32'h80, 32'd4, '0, lat, st);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL scalar_load_latency got %0d expected 3", lat); end
        checks++;
        if (load_vector !== 128'h9) begin errors++; $display("FAIL scalar_load_data got %h expected %h", load_vector, 128'h9); end
    endtask

    task automatic test_partial_negstride();
        int lat, st;
        run_seq(2'b10, 3'd2, 32'h10, 32'hFFFF_FFFC, '0, lat, st);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL partial_latency got %0d expected 4", lat); end
        checks++;
        if (load_vector !== exp_lv || load_vector[127:64] !== 64'h0) begin
            errors++; $display("FAIL partial_data got %h expected %h", load_vector, exp_lv);
        end
        run_seq(2'b11, 3'd0, 32'h300, 32'h10, {32'h4, 32'h3, 32'h2, 32'h1}, lat, st);
        checks++;
        if (lat != 5 || exp_q.size() != 0) begin
            errors++; $display("FAIL len0_store got lat=%0d pending=%0d expected lat=5 pending=0", lat, exp_q.size());
        end
        run_seq(2'b10, 3'd7, 32'h400, 32'd4, '0, lat, st);
        checks++;
        if (lat != 6 || load_vector !== exp_lv) begin
            errors++; $display("FAIL len7_load got lat=%0d lv=%h expected lat=6 lv=%h", lat, load_vector, exp_lv);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        drive_req(2'b11, 3'd4, 32'hFFFF_FFFC, 32'd4, {32'h8, 32'h7, 32'h6, 32'h5});
        @(posedge clk); #1 req_valid = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL wrap_store_latency got %0d expected 5", lat); end
        drive_req(2'b10, 3'd4, 32'h500, 32'd4, '0);
        #1;
        checks++;
        if (done !== 1'b1 || stall_cpu !== 1'b1) begin
            errors++; $display("FAIL b2b_done_cycle got done=%0b stall=%0b expected 1 1", done, stall_cpu);
        end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_re !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got re=%0b expected 1", mem_re); end
        lat = -1;
        for (int n = 2; n <= 40; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = n; break; end
        end
        checks++;
        if (lat != 6 || load_vector !== exp_lv) begin
            errors++; $display("FAIL b2b_load got lat=%0d lv=%h expected lat=6 lv=%h", lat, load_vector, exp_lv);
        end
    endtask

    task automatic test_reset_mid_load();
        int lat, st, seen;
        @(posedge clk); #1;
        drive_req(2'b10, 3'd4, 32'h600, 32'd4, '0);
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 10 && seen < 2; n++) begin
            @(negedge clk);
            if (mem_re === 1'b1) seen++;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_we, mem_re, done, stall_cpu} !== 4'b0 || load_vector !== 0) begin
            errors++; $display("FAIL mid_reset got strobes=%b lv=%h expected 0000 and 0", {mem_we, mem_re, done, stall_cpu}, load_vector);
        end
        checks++;
        if (exp_q.size() != 2) begin errors++; $display("FAIL mid_reset_issued got %0d pending expected 2", exp_q.size()); end
        exp_q.delete();
        run_seq(2'b10, 3'd3, 32'h700, 32'd4, '0, lat, st);
        checks++;
        if (lat != 5 || load_vector !== exp_lv) begin
            errors++; $display("FAIL post_reset_load got lat=%0d lv=%h expected lat=5 lv=%h", lat, load_vector, exp_lv);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = '0; req_len = '0;
        base_addr = '0; stride = '0; store_vector = '0; mem_rdata = '0;
        test_reset();
        test_vector_store();
        test_vector_load();
        test_scalar();
        test_partial_negstride();
        test_back_to_back();
        test_reset_mid_load();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
